// File: rtl/dm_pkg.sv
// dm_pkg: shared definitions for the data-memory read-modify-write controller.
//   state_t  - controller FSM states
//   BE_FULL  - byte-enable pattern for a full-word store
//   BE_NONE  - byte-enable pattern for an empty store (no lanes written)
package dm_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    RMW_RD  = 2'd2,
    RMW_WR  = 2'd3
  } state_t;

  localparam logic [3:0] BE_FULL = 4'b1111;
  localparam logic [3:0] BE_NONE = 4'b0000;

endpackage

// File: rtl/dm_rmw_ctrl_byte_merge.sv
// byte_merge: purely combinational byte-lane merge.
//   old_word in  32  word read back from RAM
//   new_word in  32  lane-aligned store data
//   be       in  4   byte enables; bit i selects new_word lane i
//   merged   out 32  lane i = be[i] ? new_word lane i : old_word lane i
module byte_merge (
  input  logic [31:0] old_word,
  input  logic [31:0] new_word,
  input  logic [3:0]  be,
  output logic [31:0] merged
);

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign merged[8*gi +: 8] = be[gi] ? new_word[8*gi +: 8] : old_word[8*gi +: 8];
  end

endmodule

// File: rtl/dm_rmw_ctrl.sv
// dm_rmw_ctrl: MEM-stage data-memory controller for a word-wide synchronous
// RAM without byte write enables. Full-word stores write directly, loads take
// one synchronous read, sub-word stores run read-modify-write with a stall.
//   clk, reset           clock; synchronous active-high reset
//   cpu_req/we/be/addr/wdata  pipeline access request (byte address, lane-aligned data)
//   cpu_rdata            load data, valid only with cpu_done on a load
//   cpu_stall, cpu_done  pipeline freeze / access completion
//   ram_addr/we/wdata    word-wide RAM write/read port
//   ram_rdata            RAM read data, one cycle after ram_addr
module dm_rmw_ctrl
  import dm_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [3:0]        cpu_be,
  input  logic [31:0]       cpu_addr,
  input  logic [31:0]       cpu_wdata,
  output logic [31:0]       cpu_rdata,
  output logic              cpu_stall,
  output logic              cpu_done,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata
);

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] addr_reg;
  logic [3:0]        be_reg;
  logic [31:0]       wdata_reg;
  logic [31:0]       merged_reg, merged_next;
  logic [31:0]       merge_out;
  logic              accept;

  // Byte-offset bits and bits above the RAM index carry no meaning here.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{cpu_addr[31:ADDR_W+2], cpu_addr[1:0]};

  byte_merge u_merge (
    .old_word (ram_rdata),
    .new_word (wdata_reg),
    .be       (be_reg),
    .merged   (merge_out)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= IDLE;
      addr_reg   <= '0;
      be_reg     <= '0;
      wdata_reg  <= '0;
      merged_reg <= '0;
    end else begin
      state_reg  <= state_next;
      merged_reg <= merged_next;
      if (accept) begin
        addr_reg  <= cpu_addr[ADDR_W+1:2];
        be_reg    <= cpu_be;
        wdata_reg <= cpu_wdata;
      end
    end
  end

  always_comb begin
    state_next  = state_reg;
    merged_next = merged_reg;
    accept      = 1'b0;
    ram_addr    = addr_reg;
    ram_we      = 1'b0;
    ram_wdata   = '0;
    cpu_stall   = 1'b0;
    cpu_done    = 1'b0;
    cpu_rdata   = '0;

    case (state_reg)
      IDLE: begin
        // RAM address comes straight from the pipeline so the read issued
        // here returns data in the following state.
        ram_addr = cpu_addr[ADDR_W+1:2];
        if (cpu_req) begin
          accept = 1'b1;
          if (cpu_we) begin
            if (cpu_be == BE_FULL) begin
              ram_we    = 1'b1;
              ram_wdata = cpu_wdata;
              cpu_done  = 1'b1;
            end else if (cpu_be == BE_NONE) begin
              cpu_done = 1'b1;
            end else begin
              cpu_stall  = 1'b1;
              state_next = RMW_RD;
            end
          end else begin
            cpu_stall  = 1'b1;
            state_next = RD_WAIT;
          end
        end
      end
      RD_WAIT: begin
        cpu_rdata  = ram_rdata;
        cpu_done   = 1'b1;
        state_next = IDLE;
      end
      RMW_RD: begin
        merged_next = merge_out;
        cpu_stall   = 1'b1;
        state_next  = RMW_WR;
      end
      RMW_WR: begin
        ram_we     = 1'b1;
        ram_wdata  = merged_reg;
        cpu_done   = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase

    // Reset forces every output quiet in the same cycle, which also
    // suppresses a pending RMW_WR write.
    if (reset) begin
      ram_addr  = '0;
      ram_we    = 1'b0;
      ram_wdata = '0;
      cpu_stall = 1'b0;
      cpu_done  = 1'b0;
      cpu_rdata = '0;
    end
  end

endmodule

// File: tb/tb_dm_rmw_ctrl.sv
module tb_dm_rmw_ctrl;

  localparam int ADDR_W = 10;

  logic              clk;
  logic              reset;
  logic              cpu_req;
  logic              cpu_we;
  logic [3:0]        cpu_be;
  logic [31:0]       cpu_addr;
  logic [31:0]       cpu_wdata;
  logic [31:0]       cpu_rdata;
  logic              cpu_stall;
  logic              cpu_done;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_we;
  logic [31:0]       ram_wdata;
  logic [31:0]       ram_rdata;

  dm_rmw_ctrl #(.ADDR_W(ADDR_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_be    (cpu_be),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .cpu_stall (cpu_stall),
    .cpu_done  (cpu_done),
    .ram_addr  (ram_addr),
    .ram_we    (ram_we),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Environment RAM: word-wide, synchronous read, no byte enables.
  logic [31:0] mem [0:(1<<ADDR_W)-1];
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  // Reference memory image maintained from the access semantics alone.
  logic [31:0] ref_mem [0:(1<<ADDR_W)-1];

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Apply one access and observe it until cpu_done (bounded).
  task automatic access(input logic we, input logic [3:0] be, input logic [31:0] addr,
                        input logic [31:0] wd, input bit churn,
                        output int lat, output int stalls, output int wes,
                        output logic [31:0] rd, output logic [ADDR_W-1:0] done_addr);
    cpu_req = 1'b1; cpu_we = we; cpu_be = be; cpu_addr = addr; cpu_wdata = wd;
    lat = 0; stalls = 0; wes = 0; rd = '0; done_addr = '0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      lat++;
      if (cpu_stall) stalls++;
      if (ram_we) wes++;
      if (cpu_done) begin
        rd = cpu_rdata;
        done_addr = ram_addr;
        break;
      end
      @(posedge clk); #1;
      if (churn) begin
        cpu_we = $urandom_range(0, 1);
        cpu_be = 4'($urandom);
        cpu_addr = $urandom;
        cpu_wdata = $urandom;
      end
    end
    @(posedge clk); #1;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_be = '0; cpu_addr = '0; cpu_wdata = '0;
  endtask

  // Reference: update image and derive expected observations.
  task automatic model(input logic we, input logic [3:0] be, input logic [31:0] addr,
                       input logic [31:0] wd,
                       output int lat, output int wes, output logic [31:0] rd);
    int w;
    w = int'(addr[ADDR_W+1:2]);
    rd = '0;
    if (!we) begin
      lat = 2; wes = 0; rd = ref_mem[w];
    end else if (be == 4'hF) begin
      lat = 1; wes = 1; ref_mem[w] = wd;
    end else if (be == 4'h0) begin
      lat = 1; wes = 0;
    end else begin
      lat = 3; wes = 1;
      for (int i = 0; i < 4; i++)
        if (be[i]) ref_mem[w][8*i +: 8] = wd[8*i +: 8];
    end
  endtask

  typedef struct {
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    bit          churn;
    int          lat;
    int          wes;
    logic [31:0] rd;
  } vec_t;

  vec_t tbl [12];

  initial begin
    int lat, stalls, wes, mlat, mwes;
    logic [31:0] rd, mrd;
    logic [ADDR_W-1:0] daddr;
    string nm;

    for (int i = 0; i < (1<<ADDR_W); i++) begin
      mem[i] = '0;
      ref_mem[i] = '0;
    end

    tbl[0]  = '{1'b1, 4'b1111, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, 1, 1, 32'h0};
    tbl[1]  = '{1'b0, 4'b0000, 32'h0000_0012, 32'h0,         1'b0, 2, 0, 32'hDEAD_BEEF};
    tbl[2]  = '{1'b1, 4'b1111, 32'h0000_0010, 32'h1122_3344, 1'b0, 1, 1, 32'h0};
    tbl[3]  = '{1'b1, 4'b0100, 32'h0000_0010, 32'hAAAA_AAAA, 1'b0, 3, 1, 32'h0};
    tbl[4]  = '{1'b0, 4'b1111, 32'h0000_0010, 32'h0,         1'b0, 2, 0, 32'h11AA_3344};
    tbl[5]  = '{1'b1, 4'b1111, 32'h0000_0010, 32'h1122_3344, 1'b0, 1, 1, 32'h0};
    tbl[6]  = '{1'b1, 4'b1100, 32'h0000_0010, 32'hBEEF_0000, 1'b0, 3, 1, 32'h0};
    tbl[7]  = '{1'b0, 4'b0000, 32'h0000_0010, 32'h0,         1'b0, 2, 0, 32'hBEEF_3344};
    tbl[8]  = '{1'b1, 4'b0000, 32'h0000_0010, 32'h1234_5678, 1'b0, 1, 0, 32'h0};
    tbl[9]  = '{1'b0, 4'b0000, 32'h0000_0010, 32'h0,         1'b0, 2, 0, 32'hBEEF_3344};
    tbl[10] = '{1'b1, 4'b0010, 32'h0000_0014, 32'h0000_5500, 1'b1, 3, 1, 32'h0};
    tbl[11] = '{1'b0, 4'b0000, 32'h0000_0014, 32'h0,         1'b0, 2, 0, 32'h0000_5500};

    // Reset cycle with an active full store request: outputs must stay quiet.
    reset = 1'b1;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_be = 4'hF; cpu_addr = 32'h10; cpu_wdata = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    @(negedge clk);
    chk("reset_ram_we", 32'(ram_we), 32'd0);
    chk("reset_stall", 32'(cpu_stall), 32'd0);
    chk("reset_done", 32'(cpu_done), 32'd0);
    chk("reset_rdata", cpu_rdata, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_be = '0; cpu_addr = '0; cpu_wdata = '0;
    @(negedge clk);
    chk("idle_stall", 32'(cpu_stall), 32'd0);
    chk("reset_no_write", mem[4], 32'd0);
    @(posedge clk); #1;

    // Directed table.
    foreach (tbl[i]) begin
      model(tbl[i].we, tbl[i].be, tbl[i].addr, tbl[i].wdata, mlat, mwes, mrd);
      access(tbl[i].we, tbl[i].be, tbl[i].addr, tbl[i].wdata, tbl[i].churn,
             lat, stalls, wes, rd, daddr);
      $display("tbl %0d we=%0b be=%b addr=%h wd=%h lat=%0d rd=%h",
               i, tbl[i].we, tbl[i].be, tbl[i].addr, tbl[i].wdata, lat, rd);
      nm = $sformatf("tbl%0d", i);
      chk({nm, "_latency"}, 32'(lat), 32'(tbl[i].lat));
      chk({nm, "_stalls"}, 32'(stalls), 32'(tbl[i].lat - 1));
      chk({nm, "_ram_we"}, 32'(wes), 32'(tbl[i].wes));
      chk({nm, "_rdata"}, rd, tbl[i].rd);
      chk({nm, "_addr"}, 32'(daddr), 32'(tbl[i].addr[ADDR_W+1:2]));
    end
    chk("word4_after_table", mem[4], 32'hBEEF_3344);
    chk("word5_after_churn", mem[5], 32'h0000_5500);

    // Reset while in RMW_WR: write dropped, access abandoned.
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_be = 4'b0001; cpu_addr = 32'h10; cpu_wdata = 32'h0000_00FF;
    @(negedge clk);
    chk("rst_rmw_c1_stall", 32'(cpu_stall), 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_rmw_c2_stall", 32'(cpu_stall), 32'd1);
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    chk("rst_rmw_ram_we", 32'(ram_we), 32'd0);
    chk("rst_rmw_done", 32'(cpu_done), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_be = '0; cpu_addr = '0; cpu_wdata = '0;
    chk("rst_rmw_word", mem[4], 32'hBEEF_3344);
    access(1'b0, 4'h0, 32'h10, 32'h0, 1'b0, lat, stalls, wes, rd, daddr);
    $display("post-reset load lat=%0d rd=%h", lat, rd);
    chk("rst_rmw_load_lat", 32'(lat), 32'd2);
    chk("rst_rmw_load_rd", rd, 32'hBEEF_3344);

    // Randomized accesses against the reference image.
    for (int t = 0; t < 300; t++) begin
      logic        rwe;
      logic [3:0]  rbe;
      logic [31:0] raddr, rwd;
      bit          rch;
      rwe = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0: rbe = 4'hF;
        1: rbe = 4'h0;
        default: rbe = 4'($urandom);
      endcase
      raddr = ($urandom & 32'hFFFF_F000) | (32'($urandom_range(0, 7)) << 2) | 32'($urandom_range(0, 3));
      rwd = $urandom;
      rch = 1'($urandom_range(0, 1));
      model(rwe, rbe, raddr, rwd, mlat, mwes, mrd);
      access(rwe, rbe, raddr, rwd, rch, lat, stalls, wes, rd, daddr);
      $display("rnd %0d we=%0b be=%b addr=%h wd=%h lat=%0d rd=%h",
               t, rwe, rbe, raddr, rwd, lat, rd);
      chk("rnd_latency", 32'(lat), 32'(mlat));
      chk("rnd_stalls", 32'(stalls), 32'(mlat - 1));
      chk("rnd_ram_we", 32'(wes), 32'(mwes));
      chk("rnd_rdata", rd, mrd);
      chk("rnd_addr", 32'(daddr), 32'(raddr[ADDR_W+1:2]));
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
      end
    end
    for (int w = 0; w < 8; w++)
      chk($sformatf("final_word%0d", w), mem[w], ref_mem[w]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/dm_rmw_ctrl.md
# dm_rmw_ctrl

Data-memory access controller in the MEM stage, between the pipeline's store/load port and a word-wide synchronous RAM with no per-byte write enable. It takes the 4-bit byte-enable produced upstream and sequences each access:
- full-word stores: direct single-cycle write;
- loads: synchronous read;
- sub-word stores (sb/sh): read-modify-write, stalling the pipeline until complete.

## Interface
Parameters:
- ADDR_W, 10, RAM word-index width (2^ADDR_W words)

Ports:
- clk  in  1  system clock; all state updates on rising edge
- reset  in  1  synchronous, active-high; one clock, sampled on clk rising edge
- cpu_req  in  1  MEM-stage access request
- cpu_we  in  1  1 = store, 0 = load
- cpu_be  in  4  byte enables, bit i = byte lane i (bits 7+8i:8i)
- cpu_addr  in  32  byte address; bits [1:0] and above ADDR_W+1 ignored
- cpu_wdata  in  32  store data, already lane-aligned
- cpu_rdata  out  32  load data, valid only while cpu_done=1 on a load
- cpu_stall  out  1  freeze pipeline this cycle
- cpu_done  out  1  access completes this cycle
- ram_addr  out  ADDR_W  word address
- ram_we  out  1  word write strobe
- ram_wdata  out  32  word write data
- ram_rdata  in  32  RAM read data, valid the cycle after ram_addr is presented

## Operation
States: IDLE, RD_WAIT, RMW_RD, RMW_WR.

IDLE decodes cpu_req combinationally; ram_addr = cpu_addr[ADDR_W+1:2]. On acceptance, latch addr, be and wdata.

Behaviour in IDLE by request type:
- No req: ram_we=0, stall=0, done=0.
- Store, be=1111: ram_we=1, ram_wdata=cpu_wdata, done=1, stall=0; stay IDLE.
- Store, be=0000: no RAM write, done=1, stall=0; stay IDLE.
- Store, other be: stall=1 -> RMW_RD.
- Load: stall=1 -> RD_WAIT. cpu_be is ignored; loads always fetch the full word, and upstream extracts the bytes.

Other states:
- RD_WAIT: cpu_rdata=ram_rdata, done=1, stall=0 -> IDLE.
- RMW_RD: capture merged word into an internal register; stall=1 -> RMW_WR. Merge rule: byte i = be_q[i] ? wdata_q byte i : ram_rdata byte i.
- RMW_WR: ram_we=1, ram_wdata=merged register, ram_addr=latched address, done=1, stall=0 -> IDLE.

Common rules:
- In all non-IDLE states, ram_addr is the latched address, and cpu_* input changes are ignored.
- ram_we is 0 in every state and case not listed above.
- cpu_rdata is 0 when cpu_done=0 or the completing access is a store.

## Timing
- Latency from acceptance to done: full/empty store 1 cycle (0 stall), load 2 cycles (1 stall), partial store 3 cycles (2 stalls).
- After done, the next request is accepted no earlier than the following cycle in IDLE. Back-to-back full-word stores sustain 1 per cycle.
- CPU holds cpu_req and operands stable while cpu_stall=1; the controller relies only on its latched copies.
- Reset: state=IDLE, latched and merge registers=0. During the reset cycle, all outputs combinationally 0 (ram_we=0, stall=0, done=0, rdata=0).
- Reset mid-operation, including in RMW_WR: no RAM write is issued, and the access is abandoned.
- cpu_req=0 while in a non-IDLE state does not abort the access; the sequence runs to completion.

## Structure
- Shared package dm_pkg: state enum, BE_FULL=4'b1111, BE_NONE=4'b0000.
- Sub-module byte_merge: purely combinational; inputs old word, new word, be; output merged word. Used in RMW_RD.
- Controller: registered state and latches, plus one combinational output decode.

## Test plan
- Full-word store: sw be=1111, addr 0x0000_0010, wdata 0xDEADBEEF -> same cycle ram_we=1, ram_addr=4, done=1, stall never asserted; RAM word 4 = 0xDEADBEEF.
- Load: word 4 = 0x11223344, load addr 0x12 -> stall=1 one cycle, then done=1 with rdata=0x11223344; ram_we never asserted.
- Byte store: word 4 = 0x11223344, be=0100, wdata=0xAAAAAAAA -> stall 2 cycles, RMW_WR writes 0x11AA3344, done=1 in cycle 3.
- Half store plus empty store: be=1100, wdata=0xBEEF0000 on word 0x11223344 -> 0xBEEF3344; then be=0000 store -> done in 1 cycle, no ram_we.
- Reset in RMW_WR: assert reset in RMW_WR -> ram_we=0 that cycle, RAM word unchanged, state IDLE afterwards, next load returns the old value.
- Input churn: change cpu_wdata and cpu_be during the stall of a partial store -> written word uses the values from the acceptance cycle.
